mmu_tlb: RTL and testbench

Next-generation MMU. It replaces the fixed direct-mapped per-segment translation table with a parametrised, fully associative, ASID-tagged TLB. The TLB is refilled by a hardware single-level page-table walker over a memory read handshake. It sits between the CPU address generation stage and the memory interface, and serves one translation request per cycle.

---
 rtl/mmu_tlb.sv | 211 +++++++++++++++++++++
 tb/tb_mmu_tlb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tlb.sv
// rtl/mmu_tlb.sv - ASID-tagged fully associative TLB with single-level hardware page-table walker
module mmu_tlb #(
   parameter int RV   = 16,
   parameter int VA   = RV,
   parameter int PA   = RV,
   parameter int PG   = 12,
   parameter int NTLB = 4,
   parameter int ASW  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mmu_enable,
   input  logic          supmode,
   input  logic          req_valid,
   input  logic          req_is_pc,
   input  logic          req_is_write,
   input  logic [VA-1:0] req_vaddr,
   output logic [PA-1:0] req_paddr,
   output logic          req_stall,
   output logic          mmu_miss_fault,
   output logic          mmu_prot_fault,
   output logic          ptw_req,
   output logic [PA-1:0] ptw_addr,
   input  logic          ptw_ack,
   input  logic [RV-1:0] ptw_data,
   input  logic          inv_all,
   input  logic          reg_write,
   input  logic [1:0]    reg_sel,
   input  logic [RV-1:0] reg_data,
   output logic [RV-1:0] reg_read
);

   localparam int VPNW = VA - PG;
   localparam int PPNW = PA - PG;
   localparam int IW   = $clog2(NTLB);

   typedef enum logic [1:0] {S_IDLE, S_WALK, S_FILL} state_e;

   state_e            state_q, state_d;
   logic [RV-1:0]     ptbr_q;
   logic [ASW-1:0]    asid_q;
   logic [RV-1:0]     fault_q;
   logic [IW-1:0]     rr_q;
   logic [PA-1:0]     ptw_addr_q;
   logic [PPNW-1:0]   pte_ppn_q;
   logic [3:0]        pte_flags_q;
   logic              cancel_q;
   logic [VPNW-1:0]   walk_vpn_q;
   logic [ASW-1:0]    walk_asid_q;
   logic              walk_ins_q;
   logic              walk_sup_q;

   logic [NTLB-1:0]   tlb_v_q;
   logic [VPNW-1:0]   tlb_vpn_q  [NTLB];
   logic [ASW-1:0]    tlb_asid_q [NTLB];
   logic [PPNW-1:0]   tlb_ppn_q  [NTLB];
   logic [2:0]        tlb_uxw_q  [NTLB];

   logic [VPNW-1:0]   req_vpn;
   logic              hit;
   logic [IW-1:0]     hit_idx;
   logic [PPNW-1:0]   hit_ppn;
   logic [2:0]        hit_uxw;
   logic              miss;
   logic              fill_en;
   logic              prot_viol;
   logic              unused_pte_bits;

   assign req_vpn = req_vaddr[VA-1:PG];
   assign unused_pte_bits = ^{ptw_data[RV-PPNW-1:4]};

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NTLB; i++) begin
         if (tlb_v_q[i] && (tlb_vpn_q[i] == req_vpn) && (tlb_asid_q[i] == asid_q)) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   assign hit_ppn = tlb_ppn_q[hit_idx];
   assign hit_uxw = tlb_uxw_q[hit_idx];
   assign miss    = req_valid & mmu_enable & ~hit;

   // hit_uxw = {user, exec, writeable}
   assign prot_viol = (req_is_pc & ~hit_uxw[1])
                    | (~req_is_pc & req_is_write & ~hit_uxw[0])
                    | (~supmode & ~hit_uxw[2]);
   assign mmu_prot_fault = req_valid & mmu_enable & hit & prot_viol;
   assign req_paddr      = mmu_enable ? {hit_ppn, req_vaddr[PG-1:0]} : PA'(req_vaddr);
   assign ptw_addr       = ptw_addr_q;

   function automatic logic [RV-1:0] fault_word(input logic [VPNW-1:0] vpn, input logic ins,
                                                input logic sup, input logic typ);
      logic [RV-1:0] f;
      f            = '0;
      f[RV-1 -: VPNW] = vpn;
      f[3:0]       = {ins, sup, typ, 1'b0};
      return f;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (miss) state_d = S_WALK;
         S_WALK:  if (ptw_ack) state_d = S_FILL;
         S_FILL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // An inv_all in the FILL cycle itself is treated like a cancel so the entry never lands valid.
   always_comb begin
      req_stall      = 1'b0;
      ptw_req        = 1'b0;
      mmu_miss_fault = 1'b0;
      fill_en        = 1'b0;
      case (state_q)
         S_IDLE: req_stall = miss;
         S_WALK: begin
            req_stall = 1'b1;
            ptw_req   = 1'b1;
         end
         S_FILL: begin
            req_stall      = 1'b1;
            fill_en        = ~cancel_q & ~inv_all & pte_flags_q[0];
            mmu_miss_fault = ~cancel_q & ~inv_all & ~pte_flags_q[0];
         end
         default: req_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptbr_q      <= '0;
         asid_q      <= '0;
         fault_q     <= '0;
         rr_q        <= '0;
         ptw_addr_q  <= '0;
         pte_ppn_q   <= '0;
         pte_flags_q <= '0;
         cancel_q    <= 1'b0;
         walk_vpn_q  <= '0;
         walk_asid_q <= '0;
         walk_ins_q  <= 1'b0;
         walk_sup_q  <= 1'b0;
         tlb_v_q     <= '0;
         for (int i = 0; i < NTLB; i++) begin
            tlb_vpn_q[i]  <= '0;
            tlb_asid_q[i] <= '0;
            tlb_ppn_q[i]  <= '0;
            tlb_uxw_q[i]  <= '0;
         end
      end else begin
         if (state_q == S_IDLE && miss) begin
            ptw_addr_q  <= PA'(ptbr_q) + PA'(req_vpn) * PA'(RV / 8);
            walk_vpn_q  <= req_vpn;
            walk_asid_q <= asid_q;
            walk_ins_q  <= req_is_pc;
            walk_sup_q  <= supmode;
         end
         if (state_q == S_WALK && ptw_ack) begin
            pte_ppn_q   <= ptw_data[RV-1 -: PPNW];
            pte_flags_q <= ptw_data[3:0];
         end
         if (state_d == S_IDLE)
            cancel_q <= 1'b0;
         else if (state_q != S_IDLE && inv_all)
            cancel_q <= 1'b1;

         if (inv_all) begin
            tlb_v_q <= '0;
         end else if (fill_en) begin
            tlb_v_q[rr_q] <= 1'b1;
         end
         if (fill_en) begin
            tlb_vpn_q[rr_q]  <= walk_vpn_q;
            tlb_asid_q[rr_q] <= walk_asid_q;
            tlb_ppn_q[rr_q]  <= pte_ppn_q;
            tlb_uxw_q[rr_q]  <= pte_flags_q[3:1];
            rr_q             <= rr_q + IW'(1);
         end

         if (reg_write && reg_sel == 2'd0) ptbr_q <= reg_data;
         if (reg_write && reg_sel == 2'd1) asid_q <= reg_data[ASW-1:0];

         if (mmu_miss_fault)
            fault_q <= fault_word(walk_vpn_q, walk_ins_q, walk_sup_q, 1'b1);
         else if (mmu_prot_fault)
            fault_q <= fault_word(req_vpn, req_is_pc, supmode, 1'b0);
      end
   end

   always_comb begin
      reg_read = '0;
      case (reg_sel)
         2'd0:    reg_read = ptbr_q;
         2'd1:    reg_read = RV'(asid_q);
         2'd2:    reg_read = fault_q;
         default: reg_read = '0;
      endcase
   end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb/tb_mmu_tlb.sv - directed bench for mmu_tlb: passthrough, walk/fill, faults, wrap, ASID, cancel, reset
module tb_mmu_tlb;

   logic        clk = 1'b0;
   logic        reset;
   logic        mmu_enable, supmode, req_valid, req_is_pc, req_is_write;
   logic [15:0] req_vaddr;
   logic [15:0] req_paddr;
   logic        req_stall, mmu_miss_fault, mmu_prot_fault, ptw_req;
   logic [15:0] ptw_addr;
   logic        ptw_ack;
   logic [15:0] ptw_data;
   logic        inv_all, reg_write;
   logic [1:0]  reg_sel;
   logic [15:0] reg_data, reg_read;

   int n_checks = 0;
   int n_fail   = 0;
   int st, wk, mf;
   logic [15:0] ad;

   mmu_tlb dut (
      .clk(clk), .reset(reset), .mmu_enable(mmu_enable), .supmode(supmode),
      .req_valid(req_valid), .req_is_pc(req_is_pc), .req_is_write(req_is_write),
      .req_vaddr(req_vaddr), .req_paddr(req_paddr), .req_stall(req_stall),
      .mmu_miss_fault(mmu_miss_fault), .mmu_prot_fault(mmu_prot_fault),
      .ptw_req(ptw_req), .ptw_addr(ptw_addr), .ptw_ack(ptw_ack), .ptw_data(ptw_data),
      .inv_all(inv_all), .reg_write(reg_write), .reg_sel(reg_sel), .reg_data(reg_data),
      .reg_read(reg_read)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] sel, input logic [15:0] data);
      reg_write = 1'b1;
      reg_sel   = sel;
      reg_data  = data;
      tick();
      reg_write = 1'b0;
   endtask

   // Serves the walker with pte after ack_wait WALK cycles; optionally fires inv_all in the first WALK cycle.
   task automatic run_walk(input logic [15:0] va, input logic pc, input logic wr,
                           input logic [15:0] pte, input int ack_wait, input bit inv_first,
                           output int stalls, output logic [15:0] addr,
                           output int walks, output int mfs);
      int w;
      w = 0; stalls = 0; walks = 0; mfs = 0; addr = '0;
      req_vaddr = va; req_is_pc = pc; req_is_write = wr; req_valid = 1'b1;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (!req_stall) break;
         stalls++;
         if (ptw_req) begin
            if (w == 0) begin
               walks++;
               if (walks == 1) addr = ptw_addr;
            end
            if (inv_first && walks == 1 && w == 0) inv_all = 1'b1;
            if (w == ack_wait) begin
               ptw_ack  = 1'b1;
               ptw_data = pte;
            end
            w++;
         end else begin
            w = 0;
         end
         if (mmu_miss_fault) mfs++;
         tick();
         ptw_ack = 1'b0;
         inv_all = 1'b0;
         if (mfs != 0) begin
            req_valid = 1'b0;
            #1;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1; mmu_enable = 1'b0; supmode = 1'b0; req_valid = 1'b0;
      req_is_pc = 1'b0; req_is_write = 1'b0; req_vaddr = '0; ptw_ack = 1'b0;
      ptw_data = '0; inv_all = 1'b0; reg_write = 1'b0; reg_sel = '0; reg_data = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check_eq("rst_stall", req_stall, 0);
      check_eq("rst_ptw_req", ptw_req, 0);
      check_eq("rst_miss_fault", mmu_miss_fault, 0);
      reg_sel = 2'd0; #1; check_eq("rst_ptbr", reg_read, 16'h0000);
      reg_sel = 2'd1; #1; check_eq("rst_asid", reg_read, 16'h0000);
      reg_sel = 2'd2; #1; check_eq("rst_fault", reg_read, 16'h0000);
      tick();
      mmu_enable = 1'b1; req_valid = 1'b1; req_vaddr = 16'h0000; #1;
      check_eq("rst_tlb_empty", req_stall, 1);
      req_valid = 1'b0; mmu_enable = 1'b0;
      tick();

      req_valid = 1'b1; req_vaddr = 16'h1234; #1;
      check_eq("pass_paddr", req_paddr, 16'h1234);
      check_eq("pass_stall", req_stall, 0);
      check_eq("pass_ptw_req", ptw_req, 0);
      req_valid = 1'b0;
      tick();

      write_reg(2'd0, 16'h8000);
      reg_sel = 2'd0; #1; check_eq("ptbr_wr", reg_read, 16'h8000);
      tick();

      mmu_enable = 1'b1; supmode = 1'b1;
      run_walk(16'h3ABC, 0, 0, 16'hC007, 0, 0, st, ad, wk, mf);
      check_eq("miss_stalls", st, 3);
      check_eq("miss_ptw_addr", ad, 16'h8006);
      check_eq("miss_walks", wk, 1);
      check_eq("hit_paddr", req_paddr, 16'hCABC);
      check_eq("hit_stall", req_stall, 0);
      check_eq("hit_prot", mmu_prot_fault, 0);
      tick();
      check_eq("hit_again_stall", req_stall, 0);

      run_walk(16'h4010, 0, 0, 16'hD007, 2, 0, st, ad, wk, mf);
      check_eq("slow_ack_stalls", st, 5);
      check_eq("slow_ack_addr", ad, 16'h8008);
      check_eq("slow_ack_paddr", req_paddr, 16'hD010);

      supmode = 1'b0;
      run_walk(16'h5000, 0, 0, 16'h0000, 0, 0, st, ad, wk, mf);
      check_eq("inv_pte_pulses", mf, 1);
      check_eq("inv_pte_stalls", st, 3);
      check_eq("inv_pte_pulse_end", mmu_miss_fault, 0);
      reg_sel = 2'd2; #1; check_eq("inv_pte_fault_reg", reg_read, 16'h5002);
      tick();

      supmode = 1'b1;
      run_walk(16'h6000, 0, 0, 16'hC003, 0, 0, st, ad, wk, mf);
      check_eq("prot_fill_paddr", req_paddr, 16'hC000);
      check_eq("prot_sup_read", mmu_prot_fault, 0);
      req_is_pc = 1'b1; #1;
      check_eq("prot_sup_fetch", mmu_prot_fault, 1);
      tick();
      req_is_pc = 1'b0; req_is_write = 1'b1; supmode = 1'b0; reg_sel = 2'd2; #1;
      check_eq("prot_fault_reg_fetch", reg_read, 16'h600C);
      check_eq("prot_user_write", mmu_prot_fault, 1);
      tick();
      supmode = 1'b1; #1;
      check_eq("prot_sup_write_ok", mmu_prot_fault, 0);
      check_eq("prot_fault_reg_write", reg_read, 16'h6000);
      tick();
      supmode = 1'b0; req_is_pc = 1'b1; req_is_write = 1'b0; #1;
      check_eq("prot_user_fetch", mmu_prot_fault, 1);
      req_valid = 1'b0; supmode = 1'b1; req_is_pc = 1'b0;
      tick();
      write_reg(2'd2, 16'hFFFF);
      write_reg(2'd3, 16'hFFFF);
      reg_sel = 2'd2; #1; check_eq("fault_reg_ro", reg_read, 16'h6000);
      reg_sel = 2'd3; #1; check_eq("sel3_read", reg_read, 16'h0000);
      reg_sel = 2'd0; #1; check_eq("sel3_wr_ignored", reg_read, 16'h8000);
      tick();

      run_walk(16'h7000, 0, 0, 16'h7007, 0, 0, st, ad, wk, mf);
      check_eq("wrap_fill4_paddr", req_paddr, 16'h7000);
      run_walk(16'h8123, 0, 0, 16'h9007, 0, 0, st, ad, wk, mf);
      check_eq("wrap_fill5_addr", ad, 16'h8010);
      check_eq("wrap_fill5_paddr", req_paddr, 16'h9123);
      tick();
      req_vaddr = 16'h3ABC; #1;
      check_eq("wrap_evicted_miss", req_stall, 1);
      req_vaddr = 16'h4010; #1;
      check_eq("wrap_entry1_hit", req_stall, 0);
      req_valid = 1'b0;
      tick();

      write_reg(2'd1, 16'h0001);
      run_walk(16'h3ABC, 0, 0, 16'hA007, 0, 0, st, ad, wk, mf);
      check_eq("asid1_walks", wk, 1);
      check_eq("asid1_paddr", req_paddr, 16'hAABC);
      write_reg(2'd1, 16'h0002);
      run_walk(16'h3ABC, 0, 0, 16'hB007, 0, 0, st, ad, wk, mf);
      check_eq("asid2_walks", wk, 1);
      check_eq("asid2_paddr", req_paddr, 16'hBABC);
      reg_write = 1'b1; reg_sel = 2'd1; reg_data = 16'h0001; #1;
      check_eq("asid_old_same_cycle", req_paddr, 16'hBABC);
      tick();
      reg_write = 1'b0; #1;
      check_eq("asid1_back_stall", req_stall, 0);
      check_eq("asid1_back_paddr", req_paddr, 16'hAABC);
      check_eq("asid1_back_no_walk", ptw_req, 0);
      req_valid = 1'b0;
      tick();

      run_walk(16'h2000, 0, 0, 16'h1007, 2, 1, st, ad, wk, mf);
      check_eq("cancel_walks", wk, 2);
      check_eq("cancel_stalls", st, 10);
      check_eq("cancel_miss_fault", mf, 0);
      check_eq("cancel_paddr", req_paddr, 16'h1000);
      req_vaddr = 16'h3ABC; #1;
      check_eq("cancel_inv_cleared", req_stall, 1);
      req_valid = 1'b0;
      tick();

      req_valid = 1'b1; req_vaddr = 16'h4000;
      tick();
      check_eq("rst_walk_req", ptw_req, 1);
      reset = 1'b1;
      tick();
      check_eq("rst_walk_req_drop", ptw_req, 0);
      reset = 1'b0; req_valid = 1'b0;
      tick();
      reg_sel = 2'd0; #1; check_eq("rst_walk_ptbr", reg_read, 16'h0000);
      req_valid = 1'b1; req_vaddr = 16'h2000; #1;
      check_eq("rst_walk_tlb_cleared", req_stall, 1);
      req_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
